// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte-substitution definitions.
//   byte_t        8-bit byte type used on every lane
//   SBOX_FWD      FIPS-197 forward S-box, 256 x 8, entry 0 first
//   SBOX_INV      FIPS-197 inverse S-box, 256 x 8, entry 0 first
//   sbox_fwd(b)   forward substitution of one byte
//   sbox_inv(b)   inverse substitution of one byte
package aes_pkg;

    typedef logic [7:0] byte_t;

    // Packed [0:255] puts entry 0 in the most significant byte, so each
    // 128-bit literal below reads as one row of the familiar 16x16 table.
    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic byte_t sbox_fwd(input byte_t b);
        return SBOX_FWD[b];
    endfunction

    function automatic byte_t sbox_inv(input byte_t b);
        return SBOX_INV[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// aes_sbox_lane: one combinational byte substitution.
//   byte_i  in   byte to substitute
//   inv_i   in   0 = forward S-box, 1 = inverse S-box (ignored if INV_EN=0)
//   byte_o  out  substituted byte
// Parameter INV_EN: 1 builds both tables, 0 builds the forward table only.
module aes_sbox_lane
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  byte_t byte_i,
    input  logic  inv_i,
    output byte_t byte_o
);

    // With INV_EN=0 the select folds to a constant and the inverse table
    // is never built.
    assign byte_o = (INV_EN && inv_i) ? sbox_inv(byte_i) : sbox_fwd(byte_i);

endmodule

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: pipelined AES SubBytes / InvSubBytes over LANES bytes.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat present
//   in_ready   out  engine accepts a beat this cycle
//   in_inv     in   0 = forward, 1 = inverse; travels with the beat
//   in_data    in   8*LANES bits, lane i = in_data[8i+7:8i]
//   out_valid  out  output beat present
//   out_ready  in   downstream accepts the beat
//   out_inv    out  mode the output beat was processed with
//   out_data   out  substituted bytes, same lane order
//   busy       out  OR of all stage valid bits
// Parameters: LANES (1..16), STAGES (1..4, accept-to-output latency),
// INV_EN (0 = forward table only, in_inv ignored).
//
// Handshake: a beat moves on a side when valid & ready are both high at the
// rising edge; a presented beat keeps valid and data stable until taken.
// The whole pipe moves together on "advance" (out_ready | ~out_valid):
// a stall freezes every stage, empty ones included, and in_ready is advance.
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int STAGES = 2,
    parameter bit INV_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_inv,
    output logic [8*LANES-1:0] out_data,
    output logic               busy
);

    localparam int DW = 8 * LANES;

    logic              advance;
    logic              inv_d;
    logic [DW-1:0]     lookup_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] inv_q;
    logic [DW-1:0]     data_q [STAGES];

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Mode carried with the beat; forced to forward when no inverse table.
    assign inv_d = INV_EN ? in_inv : 1'b0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_lane #(
            .INV_EN (INV_EN)
        ) u_lane (
            .byte_i (in_data[8*i +: 8]),
            .inv_i  (inv_d),
            .byte_o (lookup_d[8*i +: 8])
        );
    end

    // Stage 1 captures the substituted beat. Data/inv only load for a real
    // beat, so bubbles leave the last payload in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q[0] <= 1'b0;
            inv_q[0]   <= 1'b0;
            data_q[0]  <= '0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= lookup_d;
                inv_q[0]  <= inv_d;
            end
        end
    end

    // Stages 2..STAGES are pure delay under the same advance/hold rule.
    for (genvar s = 1; s < STAGES; s++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[s] <= 1'b0;
                inv_q[s]   <= 1'b0;
                data_q[s]  <= '0;
            end else if (advance) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                    inv_q[s]  <= inv_q[s-1];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_inv   = inv_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb_sub_bytes_pipe: bench for sub_bytes_pipe.
// Main instance: LANES=16, STAGES=2, INV_EN=1.
// Small instances (LANES=4): [0] STAGES=1 INV_EN=1, [1] STAGES=4 INV_EN=1,
// [2] STAGES=1 INV_EN=0. The reference S-box is derived arithmetically
// (GF(2^8) inverse plus affine map), independent of the design tables.
module tb_sub_bytes_pipe;

    localparam int DW = 128;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic          in_valid  = 1'b0;
    logic          in_inv    = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic          out_inv;
    logic [DW-1:0] out_data;
    logic          busy;

    sub_bytes_pipe #(.LANES(16), .STAGES(2), .INV_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inv   (out_inv),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- small instances ----------------
    logic        s_in_valid  = 1'b0;
    logic        s_in_inv    = 1'b0;
    logic [31:0] s_in_data   = '0;
    logic        s_out_ready = 1'b1;
    logic        s_in_ready  [3];
    logic        s_out_valid [3];
    logic        s_out_inv   [3];
    logic [31:0] s_out_data  [3];
    logic        s_busy      [3];

    sub_bytes_pipe #(.LANES(4), .STAGES(1), .INV_EN(1'b1)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[0]),
        .in_inv(s_in_inv), .in_data(s_in_data), .out_valid(s_out_valid[0]),
        .out_ready(s_out_ready), .out_inv(s_out_inv[0]), .out_data(s_out_data[0]),
        .busy(s_busy[0])
    );

    sub_bytes_pipe #(.LANES(4), .STAGES(4), .INV_EN(1'b1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[1]),
        .in_inv(s_in_inv), .in_data(s_in_data), .out_valid(s_out_valid[1]),
        .out_ready(s_out_ready), .out_inv(s_out_inv[1]), .out_data(s_out_data[1]),
        .busy(s_busy[1])
    );

    sub_bytes_pipe #(.LANES(4), .STAGES(1), .INV_EN(1'b0)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[2]),
        .in_inv(s_in_inv), .in_data(s_in_data), .out_valid(s_out_valid[2]),
        .out_ready(s_out_ready), .out_inv(s_out_inv[2]), .out_data(s_out_data[2]),
        .busy(s_busy[2])
    );

    // ---------------- reference model ----------------
    int         checks = 0;
    int         errors = 0;
    int         out_cnt = 0;
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] b;
        logic [7:0] s;
        for (int i = 0; i < 256; i++) begin
            b = 8'h00;
            for (int j = 1; j < 256; j++)
                if (gf_mul(8'(i), 8'(j)) == 8'h01) b = 8'(j);
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            fwd_t[i] = s;
            inv_t[s] = 8'(i);
        end
    endtask

    // Expected {inv, data} for a beat; lanes above 'lanes' stay zero.
    function automatic logic [DW:0] m_sub(input logic [DW-1:0] d, input logic inv,
                                          input int lanes, input bit inv_en);
        logic [DW:0] r = '0;
        logic        use_inv = inv & inv_en;
        for (int i = 0; i < lanes; i++)
            r[8*i +: 8] = use_inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        r[DW] = use_inv;
        return r;
    endfunction

    // ---------------- scoreboard: main instance ----------------
    logic [DW:0] exp_q [$];
    logic [DW:0] exp_v;
    logic [DW:0] hold_v;
    logic        hold_f = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_f = 1'b0;
        end else begin
            if (hold_f) begin
                checks++;
                if (!out_valid || {out_inv, out_data} !== hold_v) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b %h exp v=1 %h", out_valid, {out_inv, out_data}, hold_v);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got %h exp none", {out_inv, out_data});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({out_inv, out_data} !== exp_v) begin
                        errors++;
                        $display("FAIL main_out got %h exp %h", {out_inv, out_data}, exp_v);
                    end
                end
            end
            hold_f = out_valid && !out_ready;
            hold_v = {out_inv, out_data};
            if (in_valid && in_ready) exp_q.push_back(m_sub(in_data, in_inv, 16, 1'b1));
        end
    end

    // ---------------- scoreboards: small instances ----------------
    for (genvar k = 0; k < 3; k++) begin : g_mon
        localparam bit EN = (k != 2);
        logic [32:0] q [$];
        logic [32:0] e;
        logic [DW:0] r;
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                if (s_out_valid[k]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL small%0d_unexpected got %h exp none", k, {s_out_inv[k], s_out_data[k]});
                    end else begin
                        e = q.pop_front();
                        if ({s_out_inv[k], s_out_data[k]} !== e) begin
                            errors++;
                            $display("FAIL small%0d_out got %h exp %h", k, {s_out_inv[k], s_out_data[k]}, e);
                        end
                    end
                end
                if (s_in_valid && s_in_ready[k]) begin
                    r = m_sub({96'b0, s_in_data}, s_in_inv, 4, EN);
                    q.push_back({r[DW], r[31:0]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [DW-1:0] d, input logic inv);
        int n   = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout got in_ready=0 exp 1");
        end
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL drain got pending=%0d busy=%0b exp 0 0", exp_q.size(), busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, out_inv, busy, in_ready} !== 4'b0001 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%0b i=%0b b=%0b r=%0b d=%h exp 0 0 0 1 0",
                     out_valid, out_inv, busy, in_ready, out_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lane_mapping();
        logic [DW-1:0] exp_d = {16{8'h63}};
        in_valid = 1'b1;
        in_data  = '0;
        in_inv   = 1'b0;
        @(posedge clk);              // accept edge
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got out_valid=%0b exp 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_d) begin
            errors++;
            $display("FAIL lane_zero got v=%0b %h exp v=1 %h", out_valid, out_data, exp_d);
        end
        wait_drain();
    endtask

    task automatic test_fips_fwd();
        bit ok;
        tick();
        send_beat(128'h00112233445566778899aabbccddeeff, 1'b0);
        wait_out(ok);
        checks++;
        if (!ok || {out_inv, out_data} !== {1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816}) begin
            errors++;
            $display("FAIL fips_fwd got v=%0b %h exp 0 638293c31bfc33f5c4eeacea4bc12816",
                     ok, {out_inv, out_data});
        end
        wait_drain();
    endtask

    task automatic test_fips_inv();
        bit ok;
        tick();
        send_beat(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1);
        wait_out(ok);
        checks++;
        if (!ok || {out_inv, out_data} !== {1'b1, 128'h00112233445566778899aabbccddeeff}) begin
            errors++;
            $display("FAIL fips_inv got v=%0b %h exp 1 00112233445566778899aabbccddeeff",
                     ok, {out_inv, out_data});
        end
        wait_drain();
    endtask

    // 8 beats, alternating mode, out_ready low in stream cycles 4..6.
    task automatic test_mixed_backpressure();
        logic [DW-1:0] beats [8];
        int  idx = 0;
        int  cyc = 0;
        int  low = 0;
        int  base;
        bit  exp_rdy;
        for (int i = 0; i < 8; i++) beats[i] = {$urandom, $urandom, $urandom, $urandom};
        base = out_cnt;
        while (idx < 8 && cyc < 40) begin
            @(posedge clk);
            #1;
            exp_rdy   = !(cyc >= 4 && cyc <= 6);
            out_ready = exp_rdy;
            in_valid  = 1'b1;
            in_data   = beats[idx];
            in_inv    = idx[0];
            @(negedge clk);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready_cyc%0d got %0b exp %0b", cyc, in_ready, exp_rdy);
            end
            if (!in_ready) low++;
            if (in_ready) idx++;
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (low != 3) begin
            errors++;
            $display("FAIL stall_cycles got %0d exp 3", low);
        end
        wait_drain();
        checks++;
        if (out_cnt - base != 8) begin
            errors++;
            $display("FAIL stream_count got %0d exp 8", out_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        tick();
        in_valid = 1'b1;
        in_inv   = 1'b0;
        in_data  = {4{$urandom}};
        @(posedge clk);
        #1;
        in_data  = {4{$urandom}};
        in_inv   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL inflight got busy=%0b v=%0b exp 1 1", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_inv !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%0b b=%0b i=%0b d=%h exp 0 0 0 0",
                     out_valid, busy, out_inv, out_data);
        end
        tick();
        rst_n = 1'b1;
        base = out_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat_%0d got out_valid=%0b exp 0", i, out_valid);
            end
        end
        checks++;
        if (out_cnt != base) begin
            errors++;
            $display("FAIL stale_count got %0d exp 0", out_cnt - base);
        end
    endtask

    // Every lane sees all 256 values forward, then the forward results
    // inverted; the INV_EN=0 instance must keep giving forward results.
    task automatic test_exhaustive();
        logic [7:0] v;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 256; i++) begin
                tick();
                s_in_valid = 1'b1;
                s_in_inv   = (pass == 1);
                for (int k = 0; k < 4; k++) begin
                    v = 8'(i + 64 * k);
                    s_in_data[8*k +: 8] = (pass == 1) ? fwd_t[v] : v;
                end
            end
            tick();
            s_in_valid = 1'b0;
            repeat (8) tick();
        end
        checks++;
        if (g_mon[0].q.size() != 0 || g_mon[1].q.size() != 0 || g_mon[2].q.size() != 0
            || s_busy[0] || s_busy[1] || s_busy[2]) begin
            errors++;
            $display("FAIL small_drain got %0d %0d %0d exp 0 0 0",
                     g_mon[0].q.size(), g_mon[1].q.size(), g_mon[2].q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        build_tables();
        test_reset();
        test_lane_mapping();
        test_fips_fwd();
        test_fips_inv();
        test_mixed_backpressure();
        test_reset_mid();
        test_exhaustive();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog got timeout exp completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_bytes_pipe.md
Name: sub_bytes_pipe

Overview:
- Parametrised, pipelined AES SubBytes / InvSubBytes engine.
- Substitutes LANES bytes per beat, one beat per cycle.
- Uses a valid/ready handshake on both sides with global-stall backpressure.
- Successor to our single-byte combinational S-box. Feeds the round datapath and key-expansion (LANES=4 for SubWord).

Parameters:
- LANES, 16, number of byte lanes per beat (1..16); data width is 8*LANES.
- STAGES, 2, pipeline depth in register stages (1..4); accept-to-output latency in cycles.
- INV_EN, 1, 1 = forward and inverse tables built; 0 = forward only, in_inv ignored.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  engine accepts beat this cycle
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with the beat
- in_data  in  8*LANES  lane i = in_data[8i+7:8i]
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts beat
- out_inv  out  1  mode the output beat was processed with
- out_data  out  8*LANES  substituted bytes, same lane order
- busy  out  1  OR of all stage valid bits

Behaviour:
- **Reset (async assert, sync release):**
  - All stage valid bits = 0.
  - All stage data and inv registers = 0.
  - Outputs: out_valid=0, out_data=0, out_inv=0, busy=0, in_ready=1.
- **Advance signal:** advance = out_ready | ~out_valid. in_ready = advance (combinational).
- **Transfers:**
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- **Stage 1 lookup:**
  - Stage 1 register captures lookup(in_data, in_inv) on advance.
  - The lookup is applied per lane, purely combinationally, before the register.
  - Stage 1 valid captures in_valid on advance.
- **Stages 2..STAGES:** pure delay. On advance, valid, data and inv shift from the previous stage.
- **Hold rule:**
  - When advance=0, every stage holds valid, data and inv.
  - A stage's data/inv registers load only when advance=1 and the upstream valid=1. Otherwise data holds its last value; only valid updates.
- **Output mapping:** out_* is driven directly from stage STAGES registers.
- **Latency and throughput:**
  - A beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1.
  - That is STAGES cycles after the accept cycle, with out_ready held high.
  - Sustained throughput is 1 beat per cycle.
- **Bubbles:** not compressed. A stall freezes the whole pipe, including empty stages. This is required, not an optimisation gap.
- **No loss or duplication:** every accepted beat is presented exactly once. out_valid stays 1 with stable out_data/out_inv until accepted.
- **Mode mixing:** in_inv may change beat-to-beat. Each beat carries its own mode; no pipeline flush is needed between modes.
- **INV_EN=0:** in_inv is ignored; out_inv is constant 0; forward table only.
- **Simultaneous events:** input accept and output accept in the same cycle are legal; the pipe shifts once.
- **Reset mid-operation:** all in-flight beats are discarded; no output is produced for them after release.
- **Width rules:** lanes are independent; there is no cross-lane logic and no arithmetic beyond table lookup.

Decomposition:
- **aes_pkg:**
  - SBOX_FWD and SBOX_INV as 256x8 constant arrays (FIPS-197 values).
  - A byte typedef.
  - Functions sbox_fwd(byte) and sbox_inv(byte).
- **Sub-module aes_sbox_lane:** combinational.
  - Ports: byte in, inv in, byte out; INV_EN parameter.
  - Instantiated LANES times with a generate loop.
- The pipeline/handshake control lives in sub_bytes_pipe only.

Test Plan:
- **Single-byte lane mapping:** LANES=16, STAGES=2, in_inv=0, in_data=0 -> out_data = sixteen 8'h63 bytes, out_valid rises exactly 2 cycles after accept.
- **FIPS vector, forward:** in_data=128'h00112233445566778899aabbccddeeff, in_inv=0 -> out_data=128'h638293c31bfc33f5c4eeacea4bc12816, out_inv=0.
- **FIPS vector, inverse:** feed that result back with in_inv=1 -> out_data=128'h00112233445566778899aabbccddeeff, out_inv=1.
- **Mixed-mode stream with backpressure:**
  - Stimulus: 8 back-to-back beats alternating in_inv; out_ready low for 3 cycles mid-stream.
  - Required response: in_ready low in exactly those cycles; all 8 outputs appear in order, unchanged while stalled, with no drops or duplicates.
- **Reset mid-operation:** assert rst_n=0 with 2 beats in flight -> out_valid=0, out_data=0, busy=0 immediately (asynchronous); no stale beat after release.
- **Exhaustive round-trip:** LANES=4, STAGES=1 and STAGES=4; all 256 byte values per lane, forward then inverse -> identity. Repeat with INV_EN=0, confirming in_inv=1 still yields the forward result.
